// File: rtl/io_region_responder_pkg.sv
// Memory map shared by the IO region: physical address layout,
// device offsets and the request bundle seen by IO targets.
package io_region_responder_pkg;

    localparam int PHY_ADDR_WIDTH = 30;
    localparam int PHY_RAW_ADDR_WIDTH = 28;
    localparam int DATA_PATH_WIDTH = 32;
    localparam int PHY_ADDR_IS_IO_BIT = 28;
    localparam int PHY_ADDR_IS_UNCACHABLE_BIT = 29;

    typedef logic [PHY_ADDR_WIDTH-1:0] PhyAddrPath;
    typedef logic [DATA_PATH_WIDTH-1:0] DataPath;
    typedef logic [PHY_RAW_ADDR_WIDTH-1:0] PhyRawAddrPath;

    localparam int PHY_ADDR_TIMER_ZONE_BIT_WIDTH = 4;
    localparam PhyRawAddrPath PHY_ADDR_TIMER_BASE = 28'h000_0000;
    localparam PhyRawAddrPath PHY_ADDR_SERIAL_OUTPUT = 28'h000_2000;

    localparam int SERIAL_FIFO_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IO_REG_MTIME_LO    = 2'd0,
        IO_REG_MTIME_HI    = 2'd1,
        IO_REG_MTIMECMP_LO = 2'd2,
        IO_REG_MTIMECMP_HI = 2'd3
    } IoRegOffset;

    typedef struct packed {
        logic       isWrite;
        PhyAddrPath addr;
        DataPath    data;
    } MemoryIoReq;

endpackage

// File: rtl/io_region_responder_serial_tx_fifo.sv
// Synchronous TX byte FIFO in front of the UART; head byte is read
// straight from the storage registers, so a push is visible next cycle.
module serial_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) wrPtr_d = wrPtr_q + AW'(1);
        if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
        if (doPush && !doPop)      count_d = count_q + CW'(1);
        else if (doPop && !doPush) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/io_region_responder.sv
// IO region target: mtime/mtimecmp timer block plus buffered serial
// output, answering each accepted request with a one-cycle response.
module io_region_responder
    import io_region_responder_pkg::*;
#(
    parameter int SERIAL_FIFO_DEPTH = SERIAL_FIFO_DEPTH_DEFAULT,
    parameter int TIMER_PRESCALE = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqIsWrite,
    input  logic [29:0]           reqAddr,
    input  logic [DATA_WIDTH-1:0] reqWriteData,
    output logic                  respValid,
    output logic [DATA_WIDTH-1:0] respReadData,
    output logic                  respError,
    output logic                  timerIrq,
    output logic                  serialValid,
    input  logic                  serialReady,
    output logic [7:0]            serialData
);

    localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam int CW = $clog2(SERIAL_FIFO_DEPTH) + 1;

    MemoryIoReq      req;
    PhyRawAddrPath   raw;
    IoRegOffset      regSel;
    logic            isIo, timerHit, serialHit, addrErr;
    logic            accept, wrEn;
    logic            unusedUncachable;

    logic            fifoFull, fifoEmpty;
    logic [CW-1:0]   fifoCount;

    logic [PW-1:0]   prescale_q, prescale_d;
    logic [63:0]     mtime_q, mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            tick;
    logic            irq_q;

    logic                  respValid_q;
    logic [DATA_WIDTH-1:0] respData_q, respData_d;
    logic                  respErr_q, respErr_d;

    assign req = '{isWrite: reqIsWrite, addr: reqAddr, data: reqWriteData};
    assign raw = req.addr[PHY_RAW_ADDR_WIDTH-1:0];
    assign isIo = req.addr[PHY_ADDR_IS_IO_BIT];
    assign unusedUncachable = req.addr[PHY_ADDR_IS_UNCACHABLE_BIT];
    assign regSel = IoRegOffset'(raw[3:2]);

    assign timerHit = isIo &&
        (raw[PHY_RAW_ADDR_WIDTH-1:PHY_ADDR_TIMER_ZONE_BIT_WIDTH] ==
         PHY_ADDR_TIMER_BASE[PHY_RAW_ADDR_WIDTH-1:PHY_ADDR_TIMER_ZONE_BIT_WIDTH]);
    assign serialHit = isIo &&
        (raw[PHY_RAW_ADDR_WIDTH-1:2] ==
         PHY_ADDR_SERIAL_OUTPUT[PHY_RAW_ADDR_WIDTH-1:2]);
    assign addrErr = !(timerHit || serialHit);

    // Only a store to a full FIFO stalls; everything else is taken at once.
    assign reqReady = !(req.isWrite && serialHit && fifoFull);
    assign accept   = reqValid && reqReady;
    assign wrEn     = accept && req.isWrite && !addrErr;

    serial_tx_fifo #(
        .DEPTH (SERIAL_FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wrEn && serialHit),
        .pushData_i (req.data[7:0]),
        .pop_i      (serialValid && serialReady),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (fifoCount),
        .head_o     (serialData)
    );

    assign serialValid = !fifoEmpty;

    // A half-word write overrides the increment for that half only,
    // and suppresses the carry between halves for that cycle.
    always_comb begin
        tick       = (prescale_q == PW'(TIMER_PRESCALE - 1));
        prescale_d = tick ? '0 : prescale_q + PW'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wrEn && timerHit) begin
            unique case (regSel)
                IO_REG_MTIME_LO:    mtime_d = {mtime_q[63:32], req.data};
                IO_REG_MTIME_HI:    mtime_d = {req.data, mtime_q[31:0]};
                IO_REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], req.data};
                IO_REG_MTIMECMP_HI: mtimecmp_d = {req.data, mtimecmp_q[31:0]};
            endcase
        end
    end

    always_comb begin
        respData_d = '0;
        respErr_d  = 1'b0;
        if (accept) begin
            if (addrErr) begin
                respErr_d = 1'b1;
            end else if (!req.isWrite) begin
                if (serialHit) begin
                    respData_d = DATA_WIDTH'(fifoCount);
                end else begin
                    unique case (regSel)
                        IO_REG_MTIME_LO:    respData_d = mtime_q[31:0];
                        IO_REG_MTIME_HI:    respData_d = mtime_q[63:32];
                        IO_REG_MTIMECMP_LO: respData_d = mtimecmp_q[31:0];
                        IO_REG_MTIMECMP_HI: respData_d = mtimecmp_q[63:32];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_q  <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            irq_q       <= 1'b0;
            respValid_q <= 1'b0;
            respData_q  <= '0;
            respErr_q   <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            irq_q       <= (mtime_d >= mtimecmp_d);
            respValid_q <= accept;
            respData_q  <= respData_d;
            respErr_q   <= respErr_d;
        end
    end

    assign timerIrq     = irq_q;
    assign respValid    = respValid_q;
    assign respReadData = respData_q;
    assign respError    = respErr_q;

endmodule

// File: doc/io_region_responder.md
Name: io_region_responder

Overview:
- Target-side responder for the memory-mapped IO region: accepts physical IO requests (isIO=1) from the load/store unit and services two devices.
  - Timer: 64-bit mtime/mtimecmp register block at physical 0x0_0000–0x0_000F.
  - Serial output port at physical 0x0_2000, fronted by a buffered TX FIFO.
- Produces registered read/write responses, a level timer interrupt, and a valid/ready byte stream to the UART transmitter.

Parameters:
- SERIAL_FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- TIMER_PRESCALE, 1, clk cycles per mtime increment; ≥1.
- DATA_WIDTH, 32, request/response data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reqValid  in  1  request present
- reqReady  out  1  request accepted when reqValid&&reqReady
- reqIsWrite  in  1  1=store, 0=load
- reqAddr  in  30  PhyAddrPath: {isUncachable, isIO, 28-bit raw addr}
- reqWriteData  in  32  store data
- respValid  out  1  response pulse, one per accepted request
- respReadData  out  32  load data; 0 for stores
- respError  out  1  unmapped IO address or isIO=0
- timerIrq  out  1  registered (mtime >= mtimecmp)
- serialValid  out  1  byte available to UART
- serialReady  in  1  UART consumes byte
- serialData  out  8  byte to UART

Behaviour:
- Reset (synchronous, active-high):
  - mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; prescale counter=0.
  - FIFO empty.
  - respValid=0, respReadData=0, respError=0, timerIrq=0, serialValid=0, serialData=0.
  - Reset mid-transaction: any pending response and all buffered bytes are dropped, with no response.
- Address decode on raw addr; the word offset ignores bits[1:0]:
  - 0x0 mtime low, 0x4 mtime high, 0x8 mtimecmp low, 0xC mtimecmp high.
  - 0x2000 serial.
  - Anything else, or isIO=0: error.
- Handshake:
  - reqReady = !(reqIsWrite && addr==serial && fifoFull).
  - This is combinational from the request fields and never depends on respValid.
  - Every accepted request yields exactly one respValid pulse in the next cycle (latency 1). Back-to-back requests are accepted every cycle.
- Reads:
  - Timer registers return the current register value at the accept cycle.
  - Serial read returns {24'b0, fifoCount padded to 8 bits}.
  - Error response: respReadData=0, respError=1. Erroring writes have no side effects.
- Timer:
  - Prescale counter counts 0..TIMER_PRESCALE-1; mtime increments on wrap and wraps modulo 2^64.
  - A write to a mtime half in the same cycle as an increment takes the written value for that half. The other half keeps its pre-increment value; no carry is applied that cycle.
  - mtimecmp halves are written independently.
  - timerIrq is registered from the compare of the next-state values. Writing mtimecmp high-then-low above mtime drops timerIrq the cycle after the write.
- Serial:
  - An accepted serial write pushes reqWriteData[7:0].
  - FIFO output: serialValid = !empty, and serialData is the head byte (registered storage).
  - Pop on serialValid&&serialReady.
  - Simultaneous push and pop while full: push is refused by reqReady (full is evaluated before the pop).
  - Simultaneous push and pop while empty: the byte appears on serialValid the next cycle; there is no fall-through.
  - Count stays in range 0..DEPTH.

Decomposition:
- Shared memory-map package:
  - Timer/serial physical offsets and PHY_ADDR_TIMER_ZONE_BIT_WIDTH already live there.
  - Add an IoRegOffset enum and a MemoryIoReq struct {isWrite, PhyAddrPath addr, DataPath data}.
  - Add SERIAL_FIFO_DEPTH default.
- Sub-module serial_tx_fifo: parameterised synchronous FIFO with push/pop, full/empty/count outputs, registered head.
- Timer and decode stay in the top level.

Test Plan:
- Reset, then read 0x0 at cycle 5 with PRESCALE=1 → respValid next cycle, data=4 (±1 per documented sample point), respError=0; timerIrq=0.
- Write mtimecmp lo=0x20 then hi=0 → timerIrq rises the cycle after mtime reaches 0x20. Then write mtimecmp hi=1 → timerIrq=0 the following cycle.
- Write mtime lo=0xFFFF_FFFF, hi=0, then wait one increment → read hi=1, lo=0 (carry). Separately, a write to mtime lo coincident with an increment → lo holds the written value.
- serialReady=0, write 0x41..0x48 (8 bytes) → all accepted. A 9th write sees reqReady=0; a timer read in the same period is still accepted. Raise serialReady → bytes 0x41..0x48 emerge in order, and the 9th write is accepted once count<8.
- Read 0x0_0010, write 0x0_3000, and any access with isIO=0 → respError=1, respReadData=0, no state change.
- Assert rst with 3 bytes queued and a response pending → next cycle serialValid=0, respValid=0, mtime=0, mtimecmp all ones.
